// File: rtl/ac_pkg.sv
// ---------------------------------------------------------------------------
// ac_pkg
// Shared definitions for the AC zone scheduler slice.
//   MINTEMP / MAXTEMP : legal setpoint window handed to the AC datapath
//   state_t           : scheduler FSM states (IDLE, GRANT, REST)
//   ac_mode_t         : AC mode codes used by the downstream control block
// ---------------------------------------------------------------------------
package ac_pkg;

    localparam int MINTEMP = 18;
    localparam int MAXTEMP = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        REST  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        AUTOMATIC = 2'd1,
        FAST_COOL = 2'd2,
        ECO       = 2'd3
    } ac_mode_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or after
// ptr, wrapping around to zone 0.
//   req   : request vector, one bit per zone
//   ptr   : index of the highest-priority zone for this pick
//   gnt   : one-hot grant (all-zero when no request)
//   idx   : index of the granted zone (0 when no request)
//   valid : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NZONES = 4,
    parameter int IDX_W  = $clog2(NZONES)
) (
    input  logic [NZONES-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NZONES-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    // Walk priority offsets k = 0..NZONES-1 from ptr; the first live request
    // wins. The inner loop keeps all vector indices constant after unrolling.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NZONES; k++) begin
            for (int i = 0; i < NZONES; i++) begin
                if (!valid && req[i] && (i == ((int'(ptr) + k) % NZONES))) begin
                    gnt[i] = 1'b1;
                    idx    = IDX_W'(i);
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ac_zone_scheduler.sv
// ---------------------------------------------------------------------------
// ac_zone_scheduler
// Time-shares one AC unit between NZONES room zones. Zones are granted in
// round-robin order; a grant lasts at least DWELL_CYCLES before another zone
// may preempt it (voluntary release is immediate), and an optional
// compressor rest gap of REST_CYCLES separates consecutive grants.
//
// Build option:
//   AC_REST_EN  defined   -> GRANT releases into REST, busy covers REST
//               undefined -> GRANT releases straight to IDLE, busy == ac_enable
//
// Ports:
//   clk             : system clock, rising edge
//   reset           : asynchronous, active-low reset
//   zone_req        : level request per zone
//   zone_setpoint   : packed setpoints, zone i at [i*TEMP_W +: TEMP_W]
//   grant           : one-hot grant, zero when no zone is served
//   active_zone     : index of granted zone, holds last value when idle
//   active_setpoint : setpoint of granted zone, clamped and latched at grant
//   ac_enable       : high only while a zone is granted
//   busy            : high while granted (and resting, with AC_REST_EN)
// All outputs are registered.
// ---------------------------------------------------------------------------
module ac_zone_scheduler
    import ac_pkg::*;
#(
    parameter int NZONES       = 4,
    parameter int TEMP_W       = 7,
    parameter int DWELL_CYCLES = 16,
    parameter int REST_CYCLES  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NZONES-1:0]         zone_req,
    input  logic [NZONES*TEMP_W-1:0]  zone_setpoint,
    output logic [NZONES-1:0]         grant,
    output logic [$clog2(NZONES)-1:0] active_zone,
    output logic [TEMP_W-1:0]         active_setpoint,
    output logic                      ac_enable,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NZONES);
    localparam int DW_W  = $clog2(DWELL_CYCLES + 1);
    localparam int RS_W  = $clog2(REST_CYCLES + 1);

    // Saturate a requested setpoint into the window the AC datapath accepts.
    function automatic logic [TEMP_W-1:0] clamp_temp(input logic [TEMP_W-1:0] t);
        if (t < TEMP_W'(MINTEMP))
            return TEMP_W'(MINTEMP);
        else if (t > TEMP_W'(MAXTEMP))
            return TEMP_W'(MAXTEMP);
        else
            return t;
    endfunction

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [DW_W-1:0]   dwell_cnt;
    logic [RS_W-1:0]   rest_cnt;

    logic [NZONES-1:0] arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [TEMP_W-1:0] arb_setpoint;

    logic              own_req;
    logic              other_req;
    logic              dwell_done;
    logic              rest_done;
    logic              start_grant;
    logic              release_grant;
    logic [IDX_W-1:0]  next_ptr;

    rr_arbiter #(
        .NZONES (NZONES),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req   (zone_req),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Setpoint of the arbiter winner, selected by its one-hot grant.
    always_comb begin
        arb_setpoint = '0;
        for (int i = 0; i < NZONES; i++) begin
            if (arb_gnt[i])
                arb_setpoint = zone_setpoint[i*TEMP_W +: TEMP_W];
        end
    end

    assign own_req   = |(zone_req & grant);
    assign other_req = |(zone_req & ~grant);

    // dwell_cnt is 0 in the first granted cycle, so reaching DWELL_CYCLES-1
    // means this is the DWELL_CYCLES-th cycle of ac_enable: the earliest
    // point a competing zone may take over at the next edge.
    assign dwell_done = (dwell_cnt >= DW_W'(DWELL_CYCLES - 1));
    assign rest_done  = (rest_cnt == RS_W'(REST_CYCLES - 1));
    assign next_ptr   = (active_zone == IDX_W'(NZONES - 1)) ? '0 : active_zone + 1'b1;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state and transition strobes
    always_comb begin
        state_nxt     = state;
        start_grant   = 1'b0;
        release_grant = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt   = GRANT;
                    start_grant = 1'b1;
                end
            end
            GRANT: begin
                if (!own_req || (dwell_done && other_req)) begin
                    release_grant = 1'b1;
`ifdef AC_REST_EN
                    state_nxt     = REST;
`else
                    state_nxt     = IDLE;
`endif
                end
            end
            REST: begin
                if (rest_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, pointer and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant           <= '0;
            active_zone     <= '0;
            active_setpoint <= TEMP_W'(MINTEMP);
            ac_enable       <= 1'b0;
            busy            <= 1'b0;
            rr_ptr          <= '0;
            dwell_cnt       <= '0;
            rest_cnt        <= '0;
        end else begin
            ac_enable <= (state_nxt == GRANT);
            busy      <= (state_nxt != IDLE);

            if (start_grant) begin
                grant           <= arb_gnt;
                active_zone     <= arb_idx;
                active_setpoint <= clamp_temp(arb_setpoint);
                dwell_cnt       <= '0;
            end else if (state == GRANT && !release_grant &&
                         dwell_cnt != DW_W'(DWELL_CYCLES)) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end

            if (release_grant) begin
                grant    <= '0;
                rr_ptr   <= next_ptr;
                rest_cnt <= '0;
            end else if (state == REST && !rest_done) begin
                rest_cnt <= rest_cnt + 1'b1;
            end
        end
    end

endmodule
